master_port: RTL and testbench
==============================

# master_port

Master-side endpoint of the system bus: accepts one read or write command from local logic and raises a bus request to the arbiter. Once granted, it shifts the 2-bit slave select to the arbiter serially, then serialises address and write data to the selected slave, or deserialises read data. It is the initiator counterpart of the arbiter's grant and slave-select path, and is instantiated once per master (m1, m2).

## Interface
- ADDR_W, 12, address bits shifted per transaction
- DATA_W, 8, data bits per transaction
- TIMEOUT, 64, max cycles waiting for grant or slave response before abort
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_write  in  1  1=write, 0=read
- cmd_slave  in  2  target slave id
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualified by rsp_valid; 1=timeout or grant lost
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid (0 for writes/errors)
- m_request  out  1  bus request to arbiter
- m_grant  in  1  grant from arbiter
- m_slave_select  out  1  serial slave id to arbiter
- m_valid  out  1  frames serial address/write data
- m_mode  out  1  1=write, valid while m_valid
- m_dout  out  1  serial address then write data
- s_ready  in  1  slave done (write ack / read data follows)
- s_rvalid  in  1  frames serial read data
- s_din  in  1  serial read data

## Operation
- All outputs registered. Reset values: cmd_ready=1, all other outputs 0, state IDLE, counters 0.
- States: IDLE, REQ, SSEL, ADDR, WDATA, RESP, RDATA, DONE.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches cmd_* -> REQ; cmd_ready falls next cycle.
- REQ: m_request=1 (held through DONE-1). m_grant sampled 1 -> SSEL. TIMEOUT cycles without grant -> DONE with err.
- SSEL: 2 cycles, m_slave_select = cmd_slave[0] then cmd_slave[1] (LSB first, matching arbiter's slave_grant index order) -> ADDR.
- ADDR: ADDR_W cycles, m_valid=1, m_mode=cmd_write, m_dout = addr LSB first. Write -> WDATA; read -> RESP.
- WDATA: DATA_W cycles, m_dout = wdata LSB first -> RESP.
- RESP: m_valid=0; wait s_ready=1 (timeout counter restarts at RESP entry). Write -> DONE; read -> RDATA.
- RDATA: shift s_din in on each s_rvalid=1 cycle, LSB first, until DATA_W bits captured -> DONE. Timeout applies here too (counter restarts at RDATA entry).
- m_grant sampled 0 in any state SSEL..RDATA -> immediate DONE with err=1; serial outputs zeroed.
- DONE (1 cycle): m_request=0, rsp_valid=1, rsp_err/rsp_rdata driven -> IDLE. Guarantees at least one m_request-low cycle between transactions so the arbiter returns to IDLE.
- Counters: bit counter width clog2(max(ADDR_W,DATA_W))+1, timeout counter clog2(TIMEOUT)+1; no wrap, saturate at terminal.
- cmd_valid while busy is ignored (not queued).
- Reset mid-transaction: all outputs to reset values asynchronously; no rsp_valid issued for the aborted command.

## Timing
- Accept at cycle N -> m_request=1 from N+1.
- Grant first sampled 1 at cycle G -> slave-select bit0 at G+1, bit1 at G+2, address bit0 at G+3, address bit ADDR_W-1 at G+2+ADDR_W.
- Write: data bits G+3+ADDR_W .. G+2+ADDR_W+DATA_W; s_ready sampled at cycle R -> rsp_valid at R+1, cmd_ready at R+2.
- Read: last s_rvalid bit at cycle D -> rsp_valid with rdata at D+1.
- Minimum write latency accept->rsp_valid with grant and s_ready immediate: 2+2+ADDR_W+DATA_W+2 cycles.

## Structure
- Shared package bus_pkg: state enum, MODE_READ/MODE_WRITE constants, SLAVE_SEL_W=2, default ADDR_W/DATA_W.
- One sub-module: serial_shifter (parallel-load PISO plus SIPO with bit counter and done flag), used for address/wdata out and rdata in.

## Test plan
- Write slave 2'b10, addr 12'h5A3, data 8'hC4, grant after 3 cycles, s_ready immediate -> select bits 0,1; addr bits LSB first 1,1,0,0,0,1,0,1,1,0,1,0; data 0,0,1,0,0,0,1,1; rsp_valid, err=0.
- Read slave 2'b01, slave returns 8'h3D with s_rvalid gaps -> rsp_rdata=8'h3D, err=0, m_mode=0 throughout ADDR.
- Grant never asserted -> rsp_valid with err=1 exactly TIMEOUT cycles after REQ entry, m_request low in DONE.
- m_grant dropped mid-ADDR -> next cycle DONE, err=1, m_valid=0; following command accepted normally.
- Reset asserted during WDATA -> outputs at reset values same cycle, no rsp_valid, cmd_ready=1 after release.
- Back-to-back commands with cmd_valid held high -> m_request low for at least one cycle between transactions; second command accepted only in IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: constants and state encoding shared by the system-bus
// master and arbiter side logic.
package bus_pkg;
    localparam int SLAVE_SEL_W = 2;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_REQ   = 3'd1;
    localparam state_t S_SSEL  = 3'd2;
    localparam state_t S_ADDR  = 3'd3;
    localparam state_t S_WDATA = 3'd4;
    localparam state_t S_RESP  = 3'd5;
    localparam state_t S_RDATA = 3'd6;
    localparam state_t S_DONE  = 3'd7;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: parallel-load PISO / SIPO shift register with a
// saturating bit counter; exposes next-state taps so callers can register.
module serial_shifter #(
    parameter int W  = 12,
    parameter int RW = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          shift,
    input  logic          sin,
    input  logic [CW-1:0] len,
    output logic          done,
    output logic          sout_next,
    output logic [RW-1:0] rx_next
);
    logic [W-1:0]  sreg;
    logic [W-1:0]  nxt;
    logic [CW-1:0] cnt;

    always_comb begin
        nxt = sreg;
        if (load)
            nxt = load_val;
        else if (shift)
            nxt = {sin, sreg[W-1:1]};
    end

    assign sout_next = nxt[0];
    // received bits enter at the top, so the first bit ends up lowest
    assign rx_next   = nxt[W-1 -: RW];
    assign done      = (cnt == len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            sreg <= nxt;
            if (load)
                cnt <= '0;
            else if (shift && cnt != CW'(W))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/master_port.sv
// master_port: bus master endpoint; requests the arbiter, sends slave
// select, serialises address/write data and collects read data.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [SLAVE_SEL_W-1:0] cmd_slave,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   m_request,
    input  logic                   m_grant,
    output logic                   m_slave_select,
    output logic                   m_valid,
    output logic                   m_mode,
    output logic                   m_dout,
    input  logic                   s_ready,
    input  logic                   s_rvalid,
    input  logic                   s_din
);
    localparam int SW = max2(ADDR_W, DATA_W);
    localparam int CW = $clog2(SW) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t state, state_n;
    logic                   wr_q;
    logic [SLAVE_SEL_W-1:0] slave_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [TW-1:0]          tcnt;
    logic                   tout;
    logic                   sel_idx;
    logic                   err_q, err_n;
    logic                   busy;
    logic                   tx_n;

    logic          sh_load, sh_shift, sh_sin, sh_done, sh_sout;
    logic [SW-1:0] sh_val;
    logic [CW-1:0] sh_len;
    logic [DATA_W-1:0] sh_rx;

    serial_shifter #(.W(SW), .RW(DATA_W), .CW(CW)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_val  (sh_val),
        .shift     (sh_shift),
        .sin       (sh_sin),
        .len       (sh_len),
        .done      (sh_done),
        .sout_next (sh_sout),
        .rx_next   (sh_rx)
    );

    assign tout = (tcnt == TW'(TIMEOUT - 1));
    assign busy = (state != S_IDLE) && (state != S_REQ) &&
                  (state != S_DONE);

    always_comb begin
        state_n  = state;
        err_n    = err_q;
        sh_load  = 1'b0;
        sh_val   = '0;
        sh_shift = 1'b0;
        sh_sin   = 1'b0;
        sh_len   = CW'(ADDR_W - 1);
        unique case (state)
            S_IDLE: if (cmd_valid) begin
                state_n = S_REQ;
                err_n   = 1'b0;
            end
            S_REQ: if (m_grant) begin
                state_n = S_SSEL;
            end else if (tout) begin
                state_n = S_DONE;
                err_n   = 1'b1;
            end
            S_SSEL: if (sel_idx) begin
                state_n = S_ADDR;
                sh_load = 1'b1;
                sh_val  = SW'(addr_q);
            end
            S_ADDR: begin
                sh_shift = 1'b1;
                if (sh_done) begin
                    if (wr_q == MODE_WRITE) begin
                        state_n = S_WDATA;
                        sh_load = 1'b1;
                        sh_val  = SW'(wdata_q);
                    end else begin
                        state_n = S_RESP;
                    end
                end
            end
            S_WDATA: begin
                sh_shift = 1'b1;
                sh_len   = CW'(DATA_W - 1);
                if (sh_done)
                    state_n = S_RESP;
            end
            S_RESP: if (s_ready) begin
                if (wr_q == MODE_WRITE) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_RDATA;
                    sh_load = 1'b1;
                end
            end else if (tout) begin
                state_n = S_DONE;
                err_n   = 1'b1;
            end
            S_RDATA: begin
                sh_len   = CW'(DATA_W - 1);
                sh_shift = s_rvalid;
                sh_sin   = s_din;
                if (s_rvalid && sh_done) begin
                    state_n = S_DONE;
                end else if (tout) begin
                    state_n = S_DONE;
                    err_n   = 1'b1;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // losing the grant mid-transfer aborts regardless of phase
        if (busy && !m_grant) begin
            state_n  = S_DONE;
            err_n    = 1'b1;
            sh_shift = 1'b0;
        end
    end

    assign tx_n = (state_n == S_ADDR) || (state_n == S_WDATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            err_q          <= 1'b0;
            wr_q           <= 1'b0;
            slave_q        <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            tcnt           <= '0;
            sel_idx        <= 1'b0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            m_request      <= 1'b0;
            m_slave_select <= 1'b0;
            m_valid        <= 1'b0;
            m_mode         <= 1'b0;
            m_dout         <= 1'b0;
        end else begin
            state   <= state_n;
            err_q   <= err_n;
            sel_idx <= (state == S_SSEL) ? ~sel_idx : 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                wr_q    <= cmd_write;
                slave_q <= cmd_slave;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            // every state change restarts the wait budget
            if (state_n != state)
                tcnt <= '0;
            else if (!tout)
                tcnt <= tcnt + 1'b1;
            cmd_ready      <= (state_n == S_IDLE);
            m_request      <= (state_n != S_IDLE) && (state_n != S_DONE);
            m_slave_select <= (state_n == S_SSEL) &&
                              ((state == S_SSEL) ? slave_q[1] : slave_q[0]);
            m_valid        <= tx_n;
            m_mode         <= tx_n && (wr_q == MODE_WRITE);
            m_dout         <= tx_n && sh_sout;
            rsp_valid      <= (state_n == S_DONE);
            rsp_err        <= (state_n == S_DONE) && err_n;
            rsp_rdata      <= (state_n == S_DONE && !err_n &&
                               wr_q == MODE_READ) ? sh_rx : '0;
        end
    end
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: randomized scoreboard bench with arbiter/slave models
// and a reference memory for expected read data.
module tb_master_port;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [1:0] cmd_slave;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic rsp_valid, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic m_request, m_grant, m_slave_select, m_valid, m_mode, m_dout;
    logic s_ready, s_rvalid, s_din;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    logic [7:0] mem[int];

    always #5 clk = ~clk;

    master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_slave(cmd_slave),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .m_request(m_request), .m_grant(m_grant),
        .m_slave_select(m_slave_select), .m_valid(m_valid),
        .m_mode(m_mode), .m_dout(m_dout),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_din(s_din)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    function automatic int key(input logic [1:0] s, input logic [11:0] a);
        return {18'd0, s, a};
    endfunction

    function automatic logic [7:0] lookup(input logic [1:0] s,
                                          input logic [11:0] a);
        if (mem.exists(key(s, a)))
            return mem[key(s, a)];
        return a[7:0] ^ {s, a[11:6]};
    endfunction

    // scoreboard monitor: every completion pulse must match the next entry
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rsp_err", rsp_err, e[8]);
                check("rsp_rdata", rsp_rdata, e[7:0]);
            end
        end
    end

    // gdel<0: no grant; sdel<0: slave never ready;
    // drop_at: address bit after which grant drops; rst_at: wdata bit
    task automatic txn(input bit wr, input logic [1:0] sl,
                       input logic [11:0] ad, input logic [7:0] wd,
                       input int gdel, input int sdel, input int drop_at,
                       input int rst_at, input bit hold);
        logic [11:0] ga;
        logic [7:0]  gd;
        logic [1:0]  gs;
        logic [7:0]  rd;
        logic        e_err;
        logic [7:0]  e_rd;
        int          n;
        int          b;
        int          gaps;
        e_err = (gdel < 0) || (drop_at >= 0) || (sdel < 0);
        e_rd  = (e_err || wr) ? 8'h00 : lookup(sl, ad);
        if (rst_at < 0)
            exp_q.push_back({e_err, e_rd});
        if (wr && !e_err && rst_at < 0)
            mem[key(sl, ad)] = wd;
        ga = '0; gd = '0; gs = '0;

        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_slave = sl;
        cmd_addr  = ad;
        cmd_wdata = wd;
        @(negedge clk);
        if (!hold)
            cmd_valid = 1'b0;
        check("accept_req", {cmd_ready, m_request}, 2'b01);

        if (gdel < 0) begin
            n = 1;
            while (!rsp_valid && n < TIMEOUT + 10) begin
                @(negedge clk);
                if (!rsp_valid)
                    n++;
            end
            check("grant_timeout_cycles", n, TIMEOUT);
            check("grant_timeout_req_low", m_request, 0);
            return;
        end
        repeat (gdel) begin
            @(negedge clk);
            check("req_wait", {m_request, m_valid}, 2'b10);
        end
        m_grant = 1'b1;

        @(negedge clk);
        gs[0] = m_slave_select;
        check("ssel_bit0", m_slave_select, sl[0]);
        @(negedge clk);
        gs[1] = m_slave_select;
        check("ssel_bit1", m_slave_select, sl[1]);

        for (int i = 0; i < ADDR_W; i++) begin
            @(negedge clk);
            check("addr_frame", {m_valid, m_mode}, {1'b1, wr});
            ga[i] = m_dout;
            if (i == drop_at) begin
                m_grant = 1'b0;
                @(negedge clk);
                check("drop_done",
                      {rsp_valid, m_request, m_valid, m_dout}, 4'b1000);
                return;
            end
        end
        check("addr_bits", ga, ad);

        if (wr) begin
            for (int i = 0; i < DATA_W; i++) begin
                @(negedge clk);
                check("wdata_frame", {m_valid, m_mode}, 2'b11);
                gd[i] = m_dout;
                if (i == rst_at) begin
                    #1 reset = 1'b1;
                    #1;
                    check("reset_async",
                          {cmd_ready, m_request, m_valid, m_dout,
                           m_mode, rsp_valid, m_slave_select}, 7'b1000000);
                    m_grant = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    @(negedge clk);
                    check("reset_release",
                          {cmd_ready, rsp_valid, m_request}, 3'b100);
                    return;
                end
            end
            check("wdata_bits", gd, wd);
        end

        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (k == 0)
                check("resp_idle", {m_valid, m_dout, m_request}, 3'b001);
            if (sdel < 0) begin
                if (rsp_valid || k > TIMEOUT + 4) begin
                    check("resp_timeout_cycles", k, TIMEOUT);
                    m_grant = 1'b0;
                    return;
                end
            end else if (k == sdel) begin
                s_ready = 1'b1;
                @(negedge clk);
                s_ready = 1'b0;
                break;
            end
        end

        if (!wr) begin
            rd = lookup(gs, ga);
            b = 0;
            gaps = 0;
            while (b < DATA_W) begin
                if ((b == 3 && gaps == 0) ||
                    (gaps < 6 && $urandom_range(0, 2) == 0)) begin
                    s_rvalid = 1'b0;
                    gaps++;
                end else begin
                    s_rvalid = 1'b1;
                    s_din = rd[b];
                    b++;
                end
                @(negedge clk);
            end
            s_rvalid = 1'b0;
            s_din = 1'b0;
        end
        check("done_pulse", {rsp_valid, m_request, cmd_ready}, 3'b100);
        m_grant = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = '0;
        cmd_addr = '0; cmd_wdata = '0;
        m_grant = 1'b0; s_ready = 1'b0; s_rvalid = 1'b0; s_din = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cmd_ready, m_request, m_valid, m_dout, rsp_valid},
              5'b10000);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset",
              {cmd_ready, m_request, rsp_valid, m_slave_select}, 4'b1000);

        txn(1'b1, 2'b10, 12'h5A3, 8'hC4, 3, 0, -1, -1, 1'b0);
        mem[key(2'b01, 12'h0F0)] = 8'h3D;
        txn(1'b0, 2'b01, 12'h0F0, 8'h00, 1, 1, -1, -1, 1'b0);
        txn(1'b0, 2'b11, 12'h123, 8'h00, -1, 0, -1, -1, 1'b0);
        txn(1'b1, 2'b00, 12'hABC, 8'h55, 0, 0, 5, -1, 1'b0);
        txn(1'b0, 2'b00, 12'hABC, 8'h00, 0, 0, -1, -1, 1'b0);
        txn(1'b1, 2'b01, 12'h777, 8'hA5, 0, 0, -1, 3, 1'b0);
        txn(1'b0, 2'b10, 12'h010, 8'h00, 0, -1, -1, -1, 1'b0);
        txn(1'b1, 2'b11, 12'h3C3, 8'h99, 0, 0, -1, -1, 1'b1);
        txn(1'b0, 2'b11, 12'h3C3, 8'h00, 0, 0, -1, -1, 1'b1);
        for (int t = 0; t < 24; t++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                12'($urandom_range(0, 15)) ^ 12'hA50,
                8'($urandom_range(0, 255)),
                $urandom_range(0, 4), $urandom_range(0, 3), -1, -1,
                1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_idle", {cmd_ready, m_request}, 2'b10);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
